// File: rtl/disp_mode_mux.sv
// disp_mode_mux: registered display-mode selector between the BCD time counters
// and the 4-digit seven-segment scan driver.
//
// Modes (advanced by mode_btn, auto-return to HHMM after TIMEOUT_TICKS idle
// seconds):
//   0 HHMM : hours/minutes, optional blanking of a leading hour zero
//   1 MMSS : minutes/seconds, colon steady on
//   2 12H  : A/P indicator, blank, 12-hour converted hour
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   mode_btn  one-cycle debounced pulse, advances the display mode
//   tick_1hz  one-cycle 1 Hz enable
//   sec0/sec1, min0/min1, hour0/hour1  BCD time digits (ones/tens)
//   dig0..dig3  registered digit codes, dig3 leftmost
//   mode      current mode (0=HHMM, 1=MMSS, 2=12H)
//   colon     colon segment enable
//   pm        high when the current hour is 12..23 (any mode)
module disp_mode_mux #(
    parameter int unsigned BCD_W         = 4,
    parameter int unsigned TIMEOUT_TICKS = 10,
    parameter bit          LZ_BLANK      = 1'b0,
    parameter int unsigned CODE_A        = 10,
    parameter int unsigned CODE_P        = 11,
    parameter int unsigned CODE_BLANK    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_btn,
    input  logic             tick_1hz,
    input  logic [BCD_W-1:0] sec0,
    input  logic [BCD_W-1:0] sec1,
    input  logic [BCD_W-1:0] min0,
    input  logic [BCD_W-1:0] min1,
    input  logic [BCD_W-1:0] hour0,
    input  logic [BCD_W-1:0] hour1,
    output logic [BCD_W-1:0] dig0,
    output logic [BCD_W-1:0] dig1,
    output logic [BCD_W-1:0] dig2,
    output logic [BCD_W-1:0] dig3,
    output logic [1:0]       mode,
    output logic             colon,
    output logic             pm
);

    typedef enum logic [1:0] {
        StHhmm = 2'd0,
        StMmss = 2'd1,
        St12h  = 2'd2,
        StBad  = 2'd3
    } mode_e;

    // A zero-tick timeout still needs a 1-bit counter to keep the logic legal.
    localparam int unsigned CntW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
    localparam logic [CntW-1:0] CntLast =
        CntW'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);

    localparam logic [BCD_W-1:0] DigA     = BCD_W'(CODE_A);
    localparam logic [BCD_W-1:0] DigP     = BCD_W'(CODE_P);
    localparam logic [BCD_W-1:0] DigBlank = BCD_W'(CODE_BLANK);

    mode_e            mode_q, mode_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             timeout_hit;
    logic [BCD_W-1:0] dig0_q, dig0_d;
    logic [BCD_W-1:0] dig1_q, dig1_d;
    logic [BCD_W-1:0] dig2_q, dig2_d;
    logic [BCD_W-1:0] dig3_q, dig3_d;
    logic             colon_q, colon_d;
    logic             pm_q, pm_d;

    // Hour decode shared by the 12H digits and the pm flag.
    logic       hour_ok;
    logic [4:0] hour_bin;
    logic [4:0] hour12;
    logic       hour12_tens;
    logic [4:0] hour12_ones;

    //--------------------------------------------------------------------------
    // Timeout counter
    //--------------------------------------------------------------------------
    always_comb begin
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        if (mode_btn || (mode_q != StMmss && mode_q != St12h) || TIMEOUT_TICKS == 0) begin
            cnt_d = '0;
        end else if (tick_1hz) begin
            if (cnt_q == CntLast) begin
                cnt_d       = '0;
                timeout_hit = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Mode next-state; mode_btn has priority over the timeout
    //--------------------------------------------------------------------------
    always_comb begin
        mode_d = mode_q;
        unique case (mode_q)
            StHhmm: if (mode_btn) mode_d = StMmss;
            StMmss: begin
                if (mode_btn) begin
                    mode_d = St12h;
                end else if (timeout_hit) begin
                    mode_d = StHhmm;
                end
            end
            St12h: begin
                if (mode_btn || timeout_hit) begin
                    mode_d = StHhmm;
                end
            end
            StBad:  mode_d = StHhmm;
        endcase
    end

    //--------------------------------------------------------------------------
    // 24h -> 12h conversion
    //--------------------------------------------------------------------------
    always_comb begin
        hour_bin    = 5'(hour1) * 5'd10 + 5'(hour0);
        hour_ok     = (hour1 <= BCD_W'(2)) && (hour0 <= BCD_W'(9)) && (hour_bin <= 5'd23);
        hour12      = hour_bin;
        if (hour_bin == 5'd0) begin
            hour12 = 5'd12;
        end else if (hour_bin > 5'd12) begin
            hour12 = hour_bin - 5'd12;
        end
        hour12_tens = (hour12 >= 5'd10);
        hour12_ones = hour12_tens ? (hour12 - 5'd10) : hour12;
        pm_d        = hour_ok && (hour_bin >= 5'd12);
    end

    //--------------------------------------------------------------------------
    // Digit selection, keyed on the mode being loaded this edge
    //--------------------------------------------------------------------------
    always_comb begin
        dig3_d = hour1;
        dig2_d = hour0;
        dig1_d = min1;
        dig0_d = min0;
        if (LZ_BLANK && hour1 == '0) begin
            dig3_d = DigBlank;
        end
        unique case (mode_d)
            StMmss: begin
                dig3_d = min1;
                dig2_d = min0;
                dig1_d = sec1;
                dig0_d = sec0;
            end
            St12h: begin
                if (!hour_ok) begin
                    dig3_d = DigBlank;
                    dig2_d = DigBlank;
                    dig1_d = DigBlank;
                    dig0_d = DigBlank;
                end else begin
                    dig3_d = pm_d ? DigP : DigA;
                    dig2_d = DigBlank;
                    dig1_d = BCD_W'(hour12_tens);
                    dig0_d = BCD_W'(hour12_ones);
                    if (LZ_BLANK && !hour12_tens) begin
                        dig1_d = DigBlank;
                    end
                end
            end
            default: ;  // HHMM (and the unreachable encoding) use the defaults
        endcase
    end

    //--------------------------------------------------------------------------
    // Colon: steady in MMSS, restarts from 1 when leaving it, else blinks
    //--------------------------------------------------------------------------
    always_comb begin
        colon_d = colon_q;
        if (mode_d == StMmss || mode_q == StMmss) begin
            colon_d = 1'b1;
        end else if (tick_1hz) begin
            colon_d = ~colon_q;
        end
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= StHhmm;
            cnt_q   <= '0;
            dig0_q  <= '0;
            dig1_q  <= '0;
            dig2_q  <= '0;
            dig3_q  <= '0;
            colon_q <= 1'b1;
            pm_q    <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            dig0_q  <= dig0_d;
            dig1_q  <= dig1_d;
            dig2_q  <= dig2_d;
            dig3_q  <= dig3_d;
            colon_q <= colon_d;
            pm_q    <= pm_d;
        end
    end

    assign mode  = mode_q;
    assign dig0  = dig0_q;
    assign dig1  = dig1_q;
    assign dig2  = dig2_q;
    assign dig3  = dig3_q;
    assign colon = colon_q;
    assign pm    = pm_q;

endmodule

// File: tb/tb_disp_mode_mux.sv
// Directed self-checking bench for disp_mode_mux. A second instance with
// LZ_BLANK=1 shares all inputs to cover leading-zero blanking.
module tb_disp_mode_mux;

    logic       clk = 1'b0;
    logic       rst, mode_btn, tick_1hz;
    logic [3:0] sec0, sec1, min0, min1, hour0, hour1;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic [1:0] mode;
    logic       colon, pm;
    logic [3:0] lz_dig0, lz_dig1, lz_dig2, lz_dig3;
    logic [1:0] lz_mode;
    logic       lz_colon, lz_pm;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    disp_mode_mux #(.BCD_W(4), .TIMEOUT_TICKS(10), .LZ_BLANK(1'b0)) u_dut (
        .clk(clk), .rst(rst), .mode_btn(mode_btn), .tick_1hz(tick_1hz),
        .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1),
        .hour0(hour0), .hour1(hour1),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .mode(mode), .colon(colon), .pm(pm)
    );

    disp_mode_mux #(.BCD_W(4), .TIMEOUT_TICKS(10), .LZ_BLANK(1'b1)) u_dut_lz (
        .clk(clk), .rst(rst), .mode_btn(mode_btn), .tick_1hz(tick_1hz),
        .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1),
        .hour0(hour0), .hour1(hour1),
        .dig0(lz_dig0), .dig1(lz_dig1), .dig2(lz_dig2), .dig3(lz_dig3),
        .mode(lz_mode), .colon(lz_colon), .pm(lz_pm)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_digs(input string tag, input int e3, input int e2, input int e1,
                              input int e0);
        check({tag, ".dig3"}, 32'(dig3), 32'(e3));
        check({tag, ".dig2"}, 32'(dig2), 32'(e2));
        check({tag, ".dig1"}, 32'(dig1), 32'(e1));
        check({tag, ".dig0"}, 32'(dig0), 32'(e0));
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            step();
        end
    endtask

    task automatic set_hour(input int h1, input int h0);
        hour1 = 4'(h1);
        hour0 = 4'(h0);
    endtask

    // 12H sweep vectors: hour1, hour0, dig3, dig1, dig0, pm
    int sweep [6][6] = '{
        '{0, 0, 10, 1, 2, 0},
        '{0, 1, 10, 0, 1, 0},
        '{1, 1, 10, 1, 1, 0},
        '{1, 2, 11, 1, 2, 1},
        '{1, 3, 11, 0, 1, 1},
        '{2, 3, 11, 1, 1, 1}
    };

    initial begin
        rst = 1'b1; mode_btn = 1'b0; tick_1hz = 1'b0;
        set_hour(1, 3);
        min1 = 4'd4; min0 = 4'd5; sec1 = 4'd0; sec0 = 4'd7;
        step();
        step();
        check("rst.mode", 32'(mode), 0);
        check_digs("rst", 0, 0, 0, 0);
        check("rst.colon", 32'(colon), 1);
        check("rst.pm", 32'(pm), 0);

        // HHMM with 13:45:07
        rst = 1'b0;
        step();
        check("hhmm.mode", 32'(mode), 0);
        check_digs("hhmm", 1, 3, 4, 5);
        check("hhmm.pm", 32'(pm), 1);
        check("hhmm.colon0", 32'(colon), 1);
        ticks(1);
        check("hhmm.colon1", 32'(colon), 0);
        ticks(1);
        check("hhmm.colon2", 32'(colon), 1);

        // MMSS
        press();
        check("mmss.mode", 32'(mode), 1);
        check_digs("mmss", 4, 5, 0, 7);
        check("mmss.colon", 32'(colon), 1);
        ticks(1);
        check("mmss.colon_tick", 32'(colon), 1);

        // 12H
        press();
        check("12h.mode", 32'(mode), 2);
        check_digs("12h", 11, 15, 0, 1);
        check("12h.lz_dig1", 32'(lz_dig1), 15);
        check("12h.colon", 32'(colon), 1);
        ticks(1);
        check("12h.colon_tick", 32'(colon), 0);

        for (int i = 0; i < 6; i++) begin
            set_hour(sweep[i][0], sweep[i][1]);
            step();
            check($sformatf("sweep%0d.dig3", i), 32'(dig3), 32'(sweep[i][2]));
            check($sformatf("sweep%0d.dig2", i), 32'(dig2), 15);
            check($sformatf("sweep%0d.dig1", i), 32'(dig1), 32'(sweep[i][3]));
            check($sformatf("sweep%0d.dig0", i), 32'(dig0), 32'(sweep[i][4]));
            check($sformatf("sweep%0d.pm", i), 32'(pm), 32'(sweep[i][5]));
        end
        set_hour(0, 1);
        step();
        check("lz01.dig1", 32'(lz_dig1), 15);
        check("lz01.dig0", 32'(lz_dig0), 1);

        // Invalid hour 30
        set_hour(3, 0);
        step();
        check_digs("inv12h", 15, 15, 15, 15);
        check("inv12h.pm", 32'(pm), 0);
        press();
        check("invhhmm.mode", 32'(mode), 0);
        check_digs("invhhmm", 3, 0, 4, 5);

        // Timeout from MMSS on the 10th tick
        set_hour(1, 3);
        press();
        check("to.mode_start", 32'(mode), 1);
        ticks(9);
        check("to.mode_9", 32'(mode), 1);
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check("to.mode_10", 32'(mode), 0);
        check_digs("to", 1, 3, 4, 5);

        // mode_btn coinciding with the 10th tick wins
        press();
        ticks(9);
        check("co.mode_9", 32'(mode), 1);
        tick_1hz = 1'b1;
        mode_btn = 1'b1;
        step();
        tick_1hz = 1'b0;
        mode_btn = 1'b0;
        check("co.mode_btn", 32'(mode), 2);
        ticks(9);
        check("co.mode_after9", 32'(mode), 2);
        ticks(1);
        check("co.mode_after10", 32'(mode), 0);

        // Reset mid-operation in 12H with counter=7; coincident mode_btn ignored
        press();
        press();
        ticks(7);
        check("mid.mode_pre", 32'(mode), 2);
        rst = 1'b1;
        mode_btn = 1'b1;
        tick_1hz = 1'b1;
        step();
        check("mid.mode", 32'(mode), 0);
        check_digs("mid", 0, 0, 0, 0);
        check("mid.colon", 32'(colon), 1);
        check("mid.pm", 32'(pm), 0);
        rst = 1'b0;
        mode_btn = 1'b0;
        tick_1hz = 1'b0;
        step();
        check("post.mode", 32'(mode), 0);
        check_digs("post", 1, 3, 4, 5);
        check("post.colon", 32'(colon), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/disp_mode_mux.md
Name: disp_mode_mux

Overview:
- Registered, mode-switching successor to the combinational clock-display selector.
- Sits between the BCD time counters (sec/min/hour digits) and the 4-digit seven-segment scan driver.
- Steps through three display modes on a debounced button pulse and returns automatically to the default mode after an idle timeout.
- Performs correct 24h-to-12h conversion (00h shows as 12 AM), optional leading-zero blanking, and colon blink generation.

Parameters:
BCD_W, 4, width of each BCD digit bus
TIMEOUT_TICKS, 10, number of tick_1hz pulses without mode_btn before returning to HHMM mode; 0 disables timeout
LZ_BLANK, 0, 1 = blank leading zero of hour tens digit (HHMM and 12H modes)
CODE_A, 10, digit code rendered as "A"
CODE_P, 11, digit code rendered as "P"
CODE_BLANK, 15, digit code rendered as blank

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
mode_btn  in  1  one-cycle debounced pulse, advances display mode
tick_1hz  in  1  one-cycle enable pulse at 1 Hz
sec0,sec1,min0,min1,hour0,hour1  in  BCD_W each  BCD time digits (ones/tens)
dig0,dig1,dig2,dig3  out  BCD_W each  display digit codes, dig3 leftmost
mode  out  2  current mode: 0=HHMM, 1=MMSS, 2=12H
colon  out  1  colon segment enable
pm  out  1  high when displayed 12h time is PM (valid in all modes)

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: mode=0 (HHMM), dig0..dig3=0, colon=1, pm=0, timeout counter=0.
- Mode FSM, transitions sampled at rising edge of clk:
  - HHMM -(mode_btn)-> MMSS -(mode_btn)-> 12H -(mode_btn)-> HHMM.
  - Encoding 3 is unreachable; if reached, go to HHMM on the next cycle.
- Timeout counter, width clog2(TIMEOUT_TICKS+1):
  - Cleared on mode_btn and while in HHMM.
  - Increments on tick_1hz in MMSS/12H.
  - When the count equals TIMEOUT_TICKS-1 and tick_1hz is high, mode returns to HHMM and the counter clears.
  - mode_btn and timeout in the same cycle: mode_btn wins (advance, counter cleared).
  - TIMEOUT_TICKS=0: counter held at 0, no auto-return.
- Digit outputs are registered with 1-cycle latency from inputs/mode; they are computed from the mode value being loaded in the same edge (mode and digits change together).
- HHMM mode:
  - dig3=hour1, dig2=hour0, dig1=min1, dig0=min0.
  - If LZ_BLANK and hour1==0, dig3=CODE_BLANK.
- MMSS mode: dig3=min1, dig2=min0, dig1=sec1, dig0=sec0.
- 12H mode: H = 10*hour1 + hour0 (5-bit arithmetic).
  - H==0 -> 12, AM.
  - 1..11 -> H, AM.
  - 12 -> 12, PM.
  - 13..23 -> H-12, PM.
  - Output: dig3=CODE_A or CODE_P, dig2=CODE_BLANK, dig1/dig0 = BCD tens/ones of the converted hour.
  - If LZ_BLANK and converted tens==0, dig1=CODE_BLANK.
- Invalid hour (hour1>2, hour0>9, or H>23):
  - 12H mode: all four digits = CODE_BLANK, pm=0.
  - HHMM mode: raw digits are passed through.
- pm output: registered; 1 when 12<=H<=23, else 0; updated every cycle regardless of mode.
- colon output:
  - HHMM/12H: toggles on each tick_1hz.
  - MMSS: held at 1.
  - Entering MMSS forces colon=1.
  - Leaving MMSS, colon resumes toggling from 1.
- rst asserted mid-operation (any state, any counter value): all outputs and state return to reset values on that edge; rst overrides mode_btn and tick_1hz.

Test Plan:
- Reset, hour=13 min=45 sec=07, no btn -> mode=0, after 1 cycle dig3..0=1,3,4,5, pm=1; colon toggles on each tick_1hz.
- One mode_btn pulse -> next edge mode=1, dig3..0=4,5,0,7, colon=1 steady; a second pulse -> mode=2, dig3..0=11,15,0,1.
- 12H sweep with hour 00,01,11,12,13,23 -> dig3,dig1,dig0 = (10,1,2),(10,0,1),(10,1,1),(11,1,2),(11,0,1),(11,1,1); with LZ_BLANK=1, hour 01 gives dig1=15.
- Timeout in MMSS with TIMEOUT_TICKS=10 -> mode returns to 0 exactly on the 10th tick_1hz edge; mode_btn coinciding with the 10th tick -> mode=2, counter cleared, still 2 after 9 more ticks.
- Invalid hour1=3 hour0=0 in 12H -> dig3..0=15,15,15,15, pm=0; same input in HHMM -> dig3..0=3,0,min1,min0.
- rst asserted while mode=2 with counter=7 -> next edge mode=0, digits 0, colon=1, pm=0; mode_btn in the same cycle as rst is ignored.
